// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared direction and mode encodings for contador_param
package contador_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/contador_next.sv
// rtl/contador_next.sv - combinational next-count and boundary-event logic
module contador_next
  import contador_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] max,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt,
  output logic             evt
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  always_comb begin
    nxt = cur;
    evt = 1'b0;
    if (dir == DIR_UP) begin
      // values above max (from a load) count as being at the bound
      if (cur >= max) begin
        evt = 1'b1;
        nxt = (sat == MODE_SAT) ? max : ZERO;
      end else begin
        nxt = cur + ONE;
      end
    end else begin
      if (cur == ZERO) begin
        evt = 1'b1;
        nxt = (sat == MODE_SAT) ? ZERO : max;
      end else begin
        nxt = cur - ONE;
      end
    end
  end

endmodule

// File: rtl/contador_param.sv
// rtl/contador_param.sv - up/down counter with load, terminal value, TC pulse and sticky Ovf
// Optional capture register enabled by CONTADOR_CAPTURE_EN.
module contador_param
  import contador_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             Clr,
  input  logic             LA,
  input  logic [WIDTH-1:0] load,
  input  logic             En,
  input  logic             Dir,
  input  logic             Sat,
  input  logic [WIDTH-1:0] Max,
  input  logic             Ovf_clr,
`ifdef CONTADOR_CAPTURE_EN
  input  logic             Cap,
  output logic [WIDTH-1:0] Cap_out,
`endif
  output logic [WIDTH-1:0] Out,
  output logic             TC,
  output logic             Ovf
);

  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] nxt;
  logic             evt;
  logic             cnt_evt;

  contador_next #(.WIDTH(WIDTH)) u_next (
    .cur (Out),
    .max (Max),
    .dir (Dir),
    .sat (Sat),
    .nxt (nxt),
    .evt (evt)
  );

  // a boundary only counts when the count path actually wins priority
  assign cnt_evt = En & ~Clr & ~LA & evt;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      Out <= RST;
      TC  <= 1'b0;
      Ovf <= 1'b0;
    end else begin
      if (Clr) begin
        Out <= RST;
        TC  <= 1'b0;
      end else if (LA) begin
        Out <= load;
        TC  <= 1'b0;
      end else if (En) begin
        Out <= nxt;
        TC  <= evt;
      end else begin
        TC  <= 1'b0;
      end

      if (cnt_evt)
        Ovf <= 1'b1;
      else if (Ovf_clr)
        Ovf <= 1'b0;
    end
  end

`ifdef CONTADOR_CAPTURE_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      Cap_out <= '0;
    else if (Cap)
      Cap_out <= Out;
  end
`endif

endmodule

// File: tb/tb_contador_param.sv
// tb/tb_contador_param.sv - directed self-checking bench for contador_param
module tb_contador_param;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        Clr = 1'b0, LA = 1'b0, En = 1'b0, Dir = 1'b1, Sat = 1'b0, Ovf_clr = 1'b0;
  logic [11:0] load = '0, Max = '0;
  logic [11:0] Out;
  logic        TC, Ovf;
`ifdef CONTADOR_CAPTURE_EN
  logic        Cap = 1'b0;
  logic [11:0] Cap_out;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  contador_param #(.WIDTH(12), .RESET_VAL(0)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .Clr     (Clr),
    .LA      (LA),
    .load    (load),
    .En      (En),
    .Dir     (Dir),
    .Sat     (Sat),
    .Max     (Max),
    .Ovf_clr (Ovf_clr),
`ifdef CONTADOR_CAPTURE_EN
    .Cap     (Cap),
    .Cap_out (Cap_out),
`endif
    .Out     (Out),
    .TC      (TC),
    .Ovf     (Ovf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [11:0] e_out, input logic e_tc);
    step();
    check({tag, ".Out"}, Out, e_out);
    check({tag, ".TC"}, TC, e_tc);
  endtask

  logic [11:0] wrap_seq [7] = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd0, 12'd1};
  logic        wrap_tc  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #1;
    check("rst.Out", Out, 0);
    check("rst.TC", TC, 0);
    check("rst.Ovf", Ovf, 0);
    @(negedge CLK);
    reset = 1'b1;
    step();

    // wrap up 0..5
    Max = 12'd5; Sat = 1'b0; Dir = 1'b1; En = 1'b1;
    for (int i = 0; i < 7; i++) step_chk($sformatf("wrap%0d", i), wrap_seq[i], wrap_tc[i]);
    check("wrap.Ovf", Ovf, 1);

    // async reset mid-cycle
    En = 1'b0; LA = 1'b1; load = 12'h123;
    step_chk("ld123", 12'h123, 1'b0);
    LA = 1'b0; En = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("arst.Out", Out, 0);
    check("arst.TC", TC, 0);
    check("arst.Ovf", Ovf, 0);
    step();
    check("arst.hold", Out, 0);
    En = 1'b0; reset = 1'b1;
    step();

    // saturate down
    Sat = 1'b1; Dir = 1'b0; LA = 1'b1; load = 12'd2;
    step_chk("sd.ld", 12'd2, 1'b0);
    LA = 1'b0; En = 1'b1;
    step_chk("sd1", 12'd1, 1'b0);
    step_chk("sd2", 12'd0, 1'b0);
    check("sd2.Ovf", Ovf, 0);
    step_chk("sd3", 12'd0, 1'b1);
    check("sd3.Ovf", Ovf, 1);
    Ovf_clr = 1'b1;
    step_chk("sd4", 12'd0, 1'b1);
    check("sd4.Ovf", Ovf, 1);
    En = 1'b0;
    step_chk("ovfclr", 12'd0, 1'b0);
    check("ovfclr.Ovf", Ovf, 0);
    Ovf_clr = 1'b0;

    // wrap down from 0 to Max
    Sat = 1'b0; Dir = 1'b0; Max = 12'd5; En = 1'b1;
    step_chk("wd", 12'd5, 1'b1);
    step_chk("wd2", 12'd4, 1'b0);

    // saturate up holds at Max
    Sat = 1'b1; Dir = 1'b1;
    step_chk("su1", 12'd5, 1'b0);
    step_chk("su2", 12'd5, 1'b1);
    step_chk("su3", 12'd5, 1'b1);

    // priority
    Clr = 1'b1; LA = 1'b1; En = 1'b1; load = 12'hABC;
    step_chk("pri.clr", 12'h000, 1'b0);
    Clr = 1'b0;
    step_chk("pri.ld", 12'hABC, 1'b0);
    load = 12'hFFF; Max = 12'h010; En = 1'b0;
    step_chk("pri.fff", 12'hFFF, 1'b0);
    LA = 1'b0; En = 1'b1; Dir = 1'b1; Sat = 1'b0;
    step_chk("pri.up", 12'h000, 1'b1);

    // Max = 0
    Max = 12'd0;
    for (int i = 0; i < 3; i++) step_chk($sformatf("m0u%0d", i), 12'd0, 1'b1);
    Dir = 1'b0;
    step_chk("m0d", 12'd0, 1'b1);

    // above Max, counting down is a plain decrement
    En = 1'b0; LA = 1'b1; load = 12'hFFF; Max = 12'h010;
    step();
    LA = 1'b0; En = 1'b1; Dir = 1'b0;
    step_chk("gtmax", 12'hFFE, 1'b0);

`ifdef CONTADOR_CAPTURE_EN
    En = 1'b0; LA = 1'b1; load = 12'd7; Max = 12'hFFF;
    step();
    LA = 1'b0; En = 1'b1; Dir = 1'b1; Cap = 1'b1;
    step_chk("cap", 12'd8, 1'b0);
    check("cap.val", Cap_out, 7);
    Cap = 1'b0;
    step();
    check("cap.hold", Cap_out, 7);
    Clr = 1'b1;
    step();
    check("cap.clr", Cap_out, 7);
    Clr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
